// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants and types for the 4x4 keypad scanner
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Indexed by col*4 + row; rows of the physical pad read 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } scan_result_t;

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// rtl/keypad_scanner_sync_2ff.sv - two-flop synchronizer, resets to all ones (idle pull-up level)
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with scan-level debounce and key event handshake
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int COL_CYCLES     = 2500,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic [NUM_COLS-1:0] col_n,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [3:0]          key_code,
    output logic                key_valid,
    input  logic                key_ack,
    output logic                key_overrun,
    output logic                key_held,
    output logic [31:0]         digits
);

    localparam int CW = $clog2(COL_CYCLES);
    localparam int SW = $clog2(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] COL_LAST   = CW'(COL_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

    logic [CW-1:0]       col_cnt;
    logic [1:0]          col_idx;
    logic [NUM_ROWS-1:0] row_sync;
    scan_result_t        acc;
    scan_result_t        cur;
    scan_result_t        prev;
    logic [SW-1:0]       stable_cnt;
    logic [SW-1:0]       stable_next;
    logic                sample;
    logic                scan_end;
    logic                is_stable;
    logic                emit;
    logic [3:0]          emit_code;
    state_t              state;
    state_t              state_next;

    sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk (clk),
        .rst (reset),
        .d   (row_n),
        .q   (row_sync)
    );

    assign col_n     = ~(4'b0001 << col_idx);
    assign sample    = (col_cnt == COL_LAST);
    assign scan_end  = sample && (col_idx == 2'd3);
    assign key_held  = (state == HELD);
    assign emit_code = KEY_MAP[cur.idx];

    // Fold this column's rows into the running scan result; the first key found in the scan wins.
    always_comb begin
        cur = acc;
        if (!acc.hit) begin
            for (int r = NUM_ROWS - 1; r >= 0; r--) begin
                if (!row_sync[r]) begin
                    cur.hit = 1'b1;
                    cur.idx = {col_idx, 2'(r)};
                end
            end
        end
    end

    always_comb begin
        stable_next = '0;
        if (cur == prev) begin
            stable_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
        end
        is_stable = (stable_next == STABLE_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        if (scan_end && is_stable) begin
            case (state)
                IDLE: begin
                    if (cur.hit) begin
                        emit       = 1'b1;
                        state_next = HELD;
                    end
                end
                HELD: begin
                    if (!cur.hit) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt    <= '0;
            col_idx    <= 2'd0;
            acc        <= '0;
            prev       <= '0;
            stable_cnt <= '0;
        end else if (sample) begin
            col_cnt <= '0;
            col_idx <= col_idx + 2'd1;
            if (scan_end) begin
                acc        <= '0;
                prev       <= cur;
                stable_cnt <= stable_next;
            end else begin
                acc <= cur;
            end
        end else begin
            col_cnt <= col_cnt + 1'b1;
        end
    end

    // A new event beats a simultaneous acknowledge; overrun only when the old event was left unconsumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code    <= 4'h0;
            key_valid   <= 1'b0;
            key_overrun <= 1'b0;
            digits      <= 32'h0;
        end else if (emit) begin
            key_code  <= emit_code;
            key_valid <= 1'b1;
            digits    <= {digits[27:0], emit_code};
            if (key_valid && !key_ack) begin
                key_overrun <= 1'b1;
            end
        end else if (key_ack) begin
            key_valid <= 1'b0;
        end
    end

endmodule
